// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, latched request.
// Misalignment rejection is compiled in with MEM_ACCESS_ALIGN_CHECK_EN.
package mem_access_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_t;

  // Reserved size behaves exactly like a word access.
  function automatic logic is_word(size_e sz);
    return (sz == SZ_WORD) || (sz == SZ_RSVD);
  endfunction

  function automatic logic misaligned(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide memory port between the access unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/store_merge.sv
// Combinational byte-lane merge of store data into the old memory word.
module store_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    localparam logic [1:0] LN = 2'(b);
    localparam int         HB = b % 2;
    logic             hit;
    logic [LANE_W-1:0] src;

    // A half picks its pair by lane[1]; within the pair, low byte of WriteData goes low.
    always_comb begin
      case (size)
        SZ_BYTE: begin hit = (lane == LN);       src = wdata[7:0];              end
        SZ_HALF: begin hit = (lane[1] == LN[1]); src = wdata[LANE_W*HB +: LANE_W]; end
        default: begin hit = 1'b1;               src = wdata[LANE_W*b +: LANE_W];  end
      endcase
    end

    assign merged[LANE_W*b +: LANE_W] = hit ? src : old_word[LANE_W*b +: LANE_W];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: word memory port, sub-word stores via read-modify-write, ack timeout.
// Define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned half/word accesses at Start.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  mem_access_unit_if.master mem,
  output logic [31:0] MemData,
  output logic [1:0]  ByteSel,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state, state_nx;
  req_t          req_q;
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  logic          align_err;
  logic          timeout;
  logic [31:0]   merged;
  size_e         size_in;

  assign size_in = size_e'(Size);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign align_err = misaligned(size_in, Address[1:0]);
`else
  assign align_err = 1'b0;
`endif

  // An ack in the last allowed cycle still wins over the timeout.
  assign timeout = (wait_cnt == CNT_LAST) && !mem.mem_ack;

  store_merge u_merge (
    .old_word (mem.mem_rdata),
    .wdata    (req_q.wdata),
    .size     (req_q.size),
    .lane     (req_q.lane),
    .merged   (merged)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (Start) begin
        if (align_err)                         state_nx = DONE;
        else if (MemWrite && is_word(size_in)) state_nx = WR;
        else                                   state_nx = RD;
      end
      // Only sub-word stores read first, so a store in RD continues to WR.
      RD:   if (mem.mem_ack)   state_nx = req_q.we ? WR : DONE;
            else if (timeout)  state_nx = DONE;
      WR:   if (mem.mem_ack || timeout) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy        = (state != IDLE);
    Done        = (state == DONE);
    Error       = (state == DONE) && err_q;
    mem.mem_req = (state == RD) || (state == WR);
    mem.mem_we  = (state == WR);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      req_q         <= '0;
      wait_cnt      <= '0;
      err_q         <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      MemData       <= '0;
      ByteSel       <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          req_q         <= '{we: MemWrite, size: size_in, lane: Address[1:0], wdata: WriteData};
          mem.mem_addr  <= {Address[31:2], 2'b00};
          mem.mem_wdata <= WriteData;
          wait_cnt      <= '0;
          err_q         <= align_err;
        end
        RD, WR: begin
          wait_cnt <= mem.mem_ack ? '0 : wait_cnt + CW'(1);
          if (timeout) err_q <= 1'b1;
          if (state == RD && mem.mem_ack) begin
            MemData       <= mem.mem_rdata;
            ByteSel       <= req_q.lane;
            mem.mem_wdata <= merged;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hold/reset sequence, randomized ops vs a reference model.
module tb_mem_access_unit;

  localparam int T = 16;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk, Rst, Start, MemWrite;
  logic [1:0]  Size, ByteSel;
  logic [31:0] Address, WriteData, MemData;
  logic        Busy, Done, Error;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(clk), .Rst(Rst), .Start(Start), .MemWrite(MemWrite), .Size(Size),
    .Address(Address), .WriteData(WriteData), .mem(bus),
    .MemData(MemData), .ByteSel(ByteSel), .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bench memory: main process owns mem_arr, responder only reads it and logs writes.
  logic [31:0] mem_arr [int];

  function automatic logic [31:0] mem_rd(int idx);
    if (mem_arr.exists(idx)) return mem_arr[idx];
    return (32'(idx) * 32'h9E3779B9) ^ 32'h5A5AA5A5;
  endfunction

  int          ack_delay;   // req cycles before ack; negative = never
  logic        stray_ack;
  int          req_cycles = 0;
  int          wr_count   = 0;
  int          wait_cnt   = 0;
  logic [31:0] last_addr, last_wdata;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        req_cycles++;
        last_addr = bus.mem_addr;
        if (ack_delay >= 0 && wait_cnt == ack_delay) begin
          bus.mem_rdata = mem_rd(int'(bus.mem_addr >> 2));
          if (bus.mem_we) begin wr_count++; last_wdata = bus.mem_wdata; end
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
      if (stray_ack) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0; end
    end
  end

  // Reference model: latency/error/request-cycle count from the access rules.
  function automatic logic ref_misal(logic [1:0] sz, logic [1:0] lo);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return lo[0];
    return lo != 2'd0;
  endfunction

  task automatic ref_timing(input logic we, input logic [1:0] sz, input logic [1:0] lo, input int dly,
                            output int lat, output logic err, output int reqc);
    bit sub = we && (sz < 2'd2);
    if (ALIGN && ref_misal(sz, lo)) begin lat = 1; err = 1'b1; reqc = 0; end
    else if (dly < 0 || dly > T - 1) begin lat = T + 1; err = 1'b1; reqc = T; end
    else if (sub) begin lat = 3 + 2 * dly; err = 1'b0; reqc = 2 * dly + 2; end
    else begin lat = 2 + dly; err = 1'b0; reqc = dly + 1; end
  endtask

  function automatic logic [31:0] ref_merge(logic [31:0] old, logic [31:0] wd, logic [1:0] sz, logic [1:0] lo);
    int sh;
    case (sz)
      2'd0: begin sh = int'(lo) * 8;     return (old & ~(32'hFF << sh))   | ((wd & 32'hFF) << sh);   end
      2'd1: begin sh = int'(lo[1]) * 16; return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh); end
      default: return wd;
    endcase
  endfunction

  task automatic chk_reset(string tag);
    chk({tag, "_busy"},  32'(Busy), 0);
    chk({tag, "_done"},  32'(Done), 0);
    chk({tag, "_err"},   32'(Error), 0);
    chk({tag, "_req"},   32'(bus.mem_req), 0);
    chk({tag, "_we"},    32'(bus.mem_we), 0);
    chk({tag, "_addr"},  bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mdata"}, MemData, 0);
    chk({tag, "_bsel"},  32'(ByteSel), 0);
  endtask

  // One access from a negedge; ends on the negedge after Done.
  task automatic apply(string tag, logic we, logic [1:0] sz, logic [31:0] a, logic [31:0] wd, int dly,
                       int e_lat, logic e_err, logic [31:0] e_dat, int e_reqc);
    int rq0 = req_cycles;
    int wc0 = wr_count;
    int lat;
    ack_delay = dly;
    Start = 1'b1; MemWrite = we; Size = sz; Address = a; WriteData = wd;
    @(negedge clk);
    Start = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, 32'(Busy), 1);
    while (!Done && lat < 64) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(Error), 32'(e_err));
    chk({tag, "_reqc"}, 32'(req_cycles - rq0), 32'(e_reqc));
    if (e_reqc > 0) chk({tag, "_maddr"}, last_addr, {a[31:2], 2'b00});
    if (we) begin
      chk({tag, "_wrs"}, 32'(wr_count - wc0), e_err ? 0 : 1);
      if (!e_err) begin
        chk({tag, "_wdata"}, last_wdata, e_dat);
        mem_arr[int'(a >> 2)] = last_wdata;
      end
    end else begin
      chk({tag, "_wrs"}, 32'(wr_count - wc0), 0);
      if (!e_err) begin
        chk({tag, "_mdata"}, MemData, e_dat);
        chk({tag, "_bsel"}, 32'(ByteSel), 32'(a[1:0]));
      end
    end
    @(negedge clk);
    chk({tag, "_done1"}, 32'(Done), 0);
    chk({tag, "_idle"}, 32'(Busy), 0);
    if (!we && !e_err) chk({tag, "_mhold"}, MemData, e_dat);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr, wd, pre;
    int          dly, lat;
    logic        err;
    logic [31:0] dat;
    int          reqc;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt [12];
    int          rq0, e_lat, e_reqc, dly;
    logic        e_err, we;
    logic [1:0]  sz;
    logic [31:0] a, wd, e_dat;

    vt[0]  = '{1'b0, 2'd2, 32'h104, 32'h0,        32'hDEADBEEF, 0,  2,  1'b0, 32'hDEADBEEF, 1};
    vt[1]  = '{1'b1, 2'd0, 32'h203, 32'h000000AA, 32'h11223344, 0,  3,  1'b0, 32'hAA223344, 2};
    vt[2]  = '{1'b1, 2'd1, 32'h202, 32'h0000BEEF, 32'h11223344, 0,  3,  1'b0, 32'hBEEF3344, 2};
    vt[3]  = '{1'b1, 2'd2, 32'h300, 32'hCAFEF00D, 32'h0,        0,  2,  1'b0, 32'hCAFEF00D, 1};
    vt[4]  = '{1'b0, 2'd0, 32'h401, 32'h0,        32'h01020304, 2,  4,  1'b0, 32'h01020304, 3};
    vt[5]  = '{1'b1, 2'd0, 32'h500, 32'h12345677, 32'hFFFFFFFF, 1,  5,  1'b0, 32'hFFFFFF77, 4};
    vt[6]  = '{1'b1, 2'd1, 32'h600, 32'hABCD1234, 32'h55667788, 0,  3,  1'b0, 32'h55661234, 2};
    vt[7]  = '{1'b0, 2'd2, 32'h700, 32'h0,        32'h0,        -1, 17, 1'b1, 32'h0,        16};
    vt[8]  = '{1'b0, 2'd2, 32'h704, 32'h0,        32'h0BADF00D, 15, 17, 1'b0, 32'h0BADF00D, 16};
    vt[9]  = '{1'b0, 2'd2, 32'h102, 32'h0,        32'h0A0B0C0D, 0,  ALIGN ? 1 : 2, ALIGN,
               32'h0A0B0C0D, ALIGN ? 0 : 1};
    vt[10] = '{1'b1, 2'd3, 32'h800, 32'h77778888, 32'h0,        0,  2,  1'b0, 32'h77778888, 1};
    vt[11] = '{1'b1, 2'd1, 32'h901, 32'h00004321, 32'h99999999, 0,  ALIGN ? 1 : 3, ALIGN,
               ALIGN ? 32'h99999999 : 32'h99994321, ALIGN ? 0 : 2};

    Rst = 1'b1; Start = 1'b0; MemWrite = 1'b0; Size = 2'd0; Address = '0; WriteData = '0;
    ack_delay = 0; stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    chk_reset("rst");

    foreach (vt[i]) begin
      mem_arr[int'(vt[i].addr >> 2)] = vt[i].pre;
      apply($sformatf("vec%0d", i), vt[i].we, vt[i].sz, vt[i].addr, vt[i].wd, vt[i].dly,
            vt[i].lat, vt[i].err, vt[i].dat, vt[i].reqc);
    end

    // Start held through Busy with changing inputs, then reset while in RD.
    ack_delay = -1; rq0 = req_cycles;
    Start = 1'b1; MemWrite = 1'b0; Size = 2'd2; Address = 32'h104;
    @(negedge clk);
    Address = 32'h208; MemWrite = 1'b1;
    repeat (2) @(negedge clk);
    chk("hold_addr", bus.mem_addr, 32'h104);
    chk("hold_we", 32'(bus.mem_we), 0);
    chk("hold_req", 32'(bus.mem_req), 1);
    chk("hold_done", 32'(Done), 0);
    chk("hold_reqc", 32'(req_cycles - rq0), 3);
    Rst = 1'b1; Start = 1'b0;
    @(negedge clk);
    Rst = 1'b0; stray_ack = 1'b1;
    chk_reset("midrst");
    @(negedge clk);
    stray_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stray_busy%0d", k), 32'(Busy), 0);
      chk($sformatf("stray_done%0d", k), 32'(Done), 0);
      chk($sformatf("stray_req%0d", k), 32'(bus.mem_req), 0);
      @(negedge clk);
    end

    for (int k = 0; k < 40; k++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = 32'h1000 | 32'($urandom_range(0, 63));
      wd  = $urandom;
      dly = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
      ref_timing(we, sz, a[1:0], dly, e_lat, e_err, e_reqc);
      e_dat = we ? ref_merge(mem_rd(int'(a >> 2)), wd, sz, a[1:0]) : mem_rd(int'(a >> 2));
      apply($sformatf("rnd%0d", k), we, sz, a, wd, dly, e_lat, e_err, e_dat, e_reqc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum cycles to wait for mem_ack before aborting.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, a one-cycle request strobe, sampled only in IDLE.
REQ-005 SHALL have port MemWrite, input, 1, where 1 = store and 0 = load.
REQ-006 SHALL have port Size, input, 2, where 0 = byte, 1 = half, 2 = word, and 3 = reserved (treated as word).
REQ-007 SHALL have port Address, input, 32, the byte address (base + offset).
REQ-008 SHALL have port WriteData, input, 32, the store data; its low byte or half is used for sub-word stores.
REQ-009 SHALL have port mem_req, output, 1, the memory request, held high until acknowledged.
REQ-010 SHALL have port mem_we, output, 1, the memory write enable, valid while mem_req is high.
REQ-011 SHALL have port mem_addr, output, 32, the word-aligned address ({Address[31:2], 2'b00}).
REQ-012 SHALL have port mem_wdata, output, 32, the full word to write.
REQ-013 SHALL have port mem_rdata, input, 32, the memory read word, valid in the mem_ack cycle.
REQ-014 SHALL have port mem_ack, input, 1, the memory completion, a single-cycle pulse.
REQ-015 SHALL have port MemData, output, 32, the registered raw read word handed to the downstream byte/half extract stage.
REQ-016 SHALL have port ByteSel, output, 2, the registered Address[1:0] handed downstream with MemData.
REQ-017 SHALL have port Busy, output, 1, which is high whenever the state is not IDLE.
REQ-018 SHALL have port Done, output, 1, a one-cycle completion pulse.
REQ-019 SHALL have port Error, output, 1, valid with Done: timeout, or misalignment when enabled.

Function
REQ-020 SHALL implement the states IDLE, RD, WR, and DONE.
REQ-021 SHALL, in IDLE with Start=1, latch Address, WriteData, Size, and MemWrite, then transition as follows: a load goes to RD; a word store goes to WR; a byte or half store goes to RD (read-modify-write).
REQ-022 SHALL assert mem_req in the cycle after Start is sampled, with mem_we=0 in RD and 1 in WR.
REQ-023 SHALL, in RD on mem_ack, register mem_rdata, then go to DONE for a load or to WR for a sub-word store.
REQ-024 SHALL, in WR, drive mem_wdata as follows: the read word with the lane Address[1:0] replaced by WriteData[7:0] for a byte; lane Address[1] replaced by WriteData[15:0] for a half; WriteData for a word.
REQ-025 SHALL go from WR to DONE on mem_ack, and SHALL drop mem_req in the same edge.
REQ-026 SHALL go from DONE to IDLE unconditionally, with Done=1 for exactly that one cycle.
REQ-027 SHALL, for a load, present MemData and ByteSel stable from Done until the next Start is accepted.
REQ-028 SHALL keep a wait counter that clears on entry to RD or WR and increments each cycle without mem_ack; when the count reaches TIMEOUT_CYCLES-1 with no ack, it SHALL drop mem_req, go to DONE, and set Error=1.
REQ-029 SHALL give mem_ack precedence over timeout when both occur in the same cycle.
REQ-030 SHALL ignore Start while Busy, and SHALL ignore mem_ack in IDLE or DONE.
REQ-031 SHALL complete in minimum latency: load or word store, Done 2 cycles after Start when mem_ack arrives in the first request cycle; sub-word store, 3 cycles.

Reset
REQ-032 SHALL, on Rst=1 at an edge, enter IDLE and set mem_req, mem_we, Done, Error, and the counter to 0, and mem_addr, mem_wdata, MemData, and ByteSel to 0.
REQ-033 SHALL abandon an in-progress access when Rst is asserted mid-operation, with no Done issued; a pending ack after reset SHALL be ignored.

Configuration
REQ-034 SHALL, with macro MEM_ACCESS_ALIGN_CHECK_EN defined, reject at Start a half with Address[0]=1 or a word with Address[1:0]!=0 by going directly to DONE with Error=1 and no mem_req.
REQ-035 SHALL, without MEM_ACCESS_ALIGN_CHECK_EN, silently ignore the misaligned low address bits: a half uses lane Address[1], and a word uses the aligned word.

Structure
REQ-036 SHALL place the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encodings in the shared package mem_access_pkg.
REQ-037 SHALL implement the store-lane merge of REQ-024 as the combinational sub-module store_merge, with inputs old word, WriteData, Size, and Address[1:0].

Verification
REQ-038 SHALL cover a load word: Address=0x104, ack on the first request cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x104, MemData=0xDEADBEEF, ByteSel=0, Done at Start+2, Error=0.
REQ-039 SHALL cover a store byte: Address=0x203, WriteData=0x000000AA, read word 0x11223344 -> the write has mem_wdata=0xAA223344 and Done at Start+3.
REQ-040 SHALL cover a store half: Address=0x202, WriteData=0x0000BEEF, read word 0x11223344 -> mem_wdata=0xBEEF3344.
REQ-041 SHALL cover a timeout: no mem_ack with TIMEOUT_CYCLES=16 -> mem_req drops after 16 cycles, with Done=1 and Error=1.
REQ-042 SHALL cover Start held high during Busy and Rst pulsed in the RD state -> no second request, return to IDLE, no Done, and outputs at reset values.
REQ-043 SHALL cover, with MEM_ACCESS_ALIGN_CHECK_EN, a load word at 0x102 -> no mem_req, with Done and Error=1 at Start+1; without the macro, mem_addr=0x100.
